// File: rtl/snake_pkg.sv
// Shared constants and FSM state type for the cell packet parser.
// PARSER_CHECKSUM_EN adds a fifth checksum byte (and the GET_CK state).
package snake_pkg;
  localparam logic [7:0] HDR_CELL   = 8'hA5;
  localparam logic [7:0] HDR_COMMIT = 8'h5A;
  localparam int GRID_W_DEF = 14;
  localparam int GRID_H_DEF = 8;

`ifdef PARSER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, GET_X, GET_Y, GET_V, GET_CK} state_t;
`else
  typedef enum logic [1:0] {IDLE, GET_X, GET_Y, GET_V} state_t;
`endif
endpackage

// File: rtl/cell_packet_parser_if.sv
// Byte stream in, cell-update / buffer-swap strobes out.
// master: serial front end side; slave: the parser.
interface cell_packet_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] dataIn;
  logic       cell_we;
  logic       switchBuffer;
  logic [7:0] err_cnt;

  modport master (output rx_data, rx_valid,
                  input  x, y, dataIn, cell_we, switchBuffer, err_cnt);
  modport slave  (input  rx_data, rx_valid,
                  output x, y, dataIn, cell_we, switchBuffer, err_cnt);
endinterface

// File: rtl/byte_gap_timer.sv
// Idle-gap watchdog: counts clocks while enabled, restarts on clear.
// expired fires on the clock that would make the count reach TIMEOUT_CYCLES;
// a clear on that same clock suppresses it.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // gap count: zero whenever a byte arrives or the parser is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clear || !enable) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  assign expired = enable && !clear && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cell_packet_parser.sv
// Parses A5,x,y,value[,checksum] cell packets and 5A commit bytes.
// Define PARSER_CHECKSUM_EN to require a trailing x^y^value byte.
module cell_packet_parser
  import snake_pkg::*;
#(
  parameter int GRID_W         = GRID_W_DEF,
  parameter int GRID_H         = GRID_H_DEF,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  cell_packet_parser_if.slave bus
);
  localparam logic [8:0] GW = 9'(GRID_W);
  localparam logic [8:0] GH = 9'(GRID_H);

  state_t     st, st_nxt;
  logic [7:0] xr, yr;
  logic [7:0] x_q, y_q, d_q, err_q;
  logic       we_q, sb_q;
  logic       wr_ok, commit, drop, expired, in_range;
  logic [7:0] wr_v;
`ifdef PARSER_CHECKSUM_EN
  logic [7:0] vr;
  assign wr_v = vr;
`else
  assign wr_v = bus.rx_data;
`endif

  byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.rx_valid),
    .enable  (st != IDLE),
    .expired (expired)
  );

  assign in_range = ({1'b0, xr} < GW) && ({1'b0, yr} < GH);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // next state plus end-of-packet verdict (write / commit / drop)
  always_comb begin
    st_nxt = st;
    wr_ok  = 1'b0;
    commit = 1'b0;
    drop   = 1'b0;
    if (expired) begin
      st_nxt = IDLE;
      drop   = 1'b1;
    end else if (bus.rx_valid) begin
      case (st)
        IDLE: begin
          if (bus.rx_data == HDR_CELL)        st_nxt = GET_X;
          else if (bus.rx_data == HDR_COMMIT) commit = 1'b1;
        end
        GET_X: st_nxt = GET_Y;
        GET_Y: st_nxt = GET_V;
`ifdef PARSER_CHECKSUM_EN
        GET_V: st_nxt = GET_CK;
        GET_CK: begin
          st_nxt = IDLE;
          if (in_range && (bus.rx_data == (xr ^ yr ^ vr))) wr_ok = 1'b1;
          else                                             drop  = 1'b1;
        end
`else
        GET_V: begin
          st_nxt = IDLE;
          if (in_range) wr_ok = 1'b1;
          else          drop  = 1'b1;
        end
`endif
        default: st_nxt = IDLE;
      endcase
    end
  end

  // capture packet fields as they stream in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr <= '0;
      yr <= '0;
`ifdef PARSER_CHECKSUM_EN
      vr <= '0;
`endif
    end else if (bus.rx_valid) begin
      case (st)
        GET_X: xr <= bus.rx_data;
        GET_Y: yr <= bus.rx_data;
`ifdef PARSER_CHECKSUM_EN
        GET_V: vr <= bus.rx_data;
`endif
        default: ;
      endcase
    end
  end

  // registered outputs: strobes, held cell update, saturating drop count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      d_q   <= '0;
      err_q <= '0;
      we_q  <= 1'b0;
      sb_q  <= 1'b0;
    end else begin
      we_q <= wr_ok;
      sb_q <= commit;
      if (wr_ok) begin
        x_q <= xr;
        y_q <= yr;
        d_q <= wr_v;
      end
      if (drop && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.dataIn       = d_q;
  assign bus.cell_we      = we_q;
  assign bus.switchBuffer = sb_q;
  assign bus.err_cnt      = err_q;
endmodule

// File: tb/tb_cell_packet_parser.sv
// Directed bench for cell_packet_parser with a packet-queue reference model.
module tb_cell_packet_parser;
  localparam int GW = 14;
  localparam int GH = 8;
  localparam int TO = 40;
`ifdef PARSER_CHECKSUM_EN
  localparam int PLEN = 5;
`else
  localparam int PLEN = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cell_packet_parser_if bus();

  cell_packet_parser #(.GRID_W(GW), .GRID_H(GH), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  // reference model: packet bytes collected so far, idle-clock count
  logic [7:0] pkt[$];
  int         gap;
  logic [7:0] mx, my, md, merr;
  logic       mwe, msb;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pkt.delete();
    gap = 0;
    mx = 0; my = 0; md = 0; merr = 0; mwe = 0; msb = 0;
  endtask

  task automatic bump();
    if (merr != 8'd255) merr = merr + 8'd1;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic ok;
    mwe = 0;
    msb = 0;
    if (pkt.size() == 0) begin
      if (v && d == 8'hA5) begin
        pkt.push_back(d);
        gap = 0;
      end else if (v && d == 8'h5A) msb = 1;
    end else if (v) begin
      pkt.push_back(d);
      gap = 0;
      if (pkt.size() == PLEN) begin
        ok = (int'(pkt[1]) < GW) && (int'(pkt[2]) < GH);
`ifdef PARSER_CHECKSUM_EN
        if (pkt[4] != (pkt[1] ^ pkt[2] ^ pkt[3])) ok = 0;
`endif
        if (ok) begin
          mwe = 1; mx = pkt[1]; my = pkt[2]; md = pkt[3];
        end else bump();
        pkt.delete();
      end
    end else begin
      gap++;
      if (gap == TO) begin
        bump();
        pkt.delete();
        gap = 0;
      end
    end
  endtask

  // compare every cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cell_we", {7'd0, bus.cell_we}, {7'd0, mwe});
      chk("switchBuffer", {7'd0, bus.switchBuffer}, {7'd0, msb});
      chk("err_cnt", bus.err_cnt, merr);
      chk("x", bus.x, mx);
      chk("y", bus.y, my);
      chk("dataIn", bus.dataIn, md);
      chk("we_sb_excl", {7'd0, bus.cell_we & bus.switchBuffer}, 8'd0);
    end
  end

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    if (!rst) model_step(v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_cell(input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] cv);
    step(1'b1, 8'hA5);
    step(1'b1, cx);
    step(1'b1, cy);
    step(1'b1, cv);
`ifdef PARSER_CHECKSUM_EN
    step(1'b1, cx ^ cy ^ cv);
`endif
  endtask

  task automatic send_bad();
`ifdef PARSER_CHECKSUM_EN
    step(1'b1, 8'hA5); step(1'b1, 8'h01); step(1'b1, 8'h01);
    step(1'b1, 8'h01); step(1'b1, 8'hFF);
`else
    send_cell(8'd20, 8'd1, 8'd1);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("lit_rst_err", bus.err_cnt, 8'd0);
    chk("lit_rst_x", bus.x, 8'd0);

    // basic cell write
    send_cell(8'd3, 8'd2, 8'd1);
    chk("lit_we", {7'd0, bus.cell_we}, 8'd1);
    chk("lit_x", bus.x, 8'd3);
    chk("lit_y", bus.y, 8'd2);
    chk("lit_d", bus.dataIn, 8'd1);
    chk("lit_model_err0", merr, 8'd0);
    idle(2);

    // out of range x, then out of range y
    send_cell(8'h0E, 8'h00, 8'h01);
    chk("lit_oor_we", {7'd0, bus.cell_we}, 8'd0);
    chk("lit_oor_err1", bus.err_cnt, 8'd1);
    send_cell(8'h00, 8'h08, 8'h01);
    chk("lit_oor_err2", bus.err_cnt, 8'd2);
    chk("lit_oor_x_held", bus.x, 8'd3);

    // commit in idle, and 5A as packet data
    step(1'b1, 8'h5A);
    chk("lit_sb", {7'd0, bus.switchBuffer}, 8'd1);
    idle(1);
    chk("lit_sb_once", {7'd0, bus.switchBuffer}, 8'd0);
    send_cell(8'h5A, 8'h01, 8'h01);
    chk("lit_5a_x_err", bus.err_cnt, 8'd3);
    send_cell(8'h01, 8'h02, 8'h5A);
    chk("lit_5a_val", bus.dataIn, 8'h5A);
    step(1'b1, 8'h33);
    idle(1);

    // timeout after A5,03
    step(1'b1, 8'hA5);
    step(1'b1, 8'h03);
    idle(TO - 1);
    chk("lit_to_pre", bus.err_cnt, 8'd3);
    idle(1);
    chk("lit_to_err", bus.err_cnt, 8'd4);
    send_cell(8'd4, 8'd5, 8'd0);
    chk("lit_to_after_x", bus.x, 8'd4);

    // byte arriving on the expiry clock wins
    step(1'b1, 8'hA5);
    idle(TO - 1);
    send_cell_tail(8'd6, 8'd7, 8'd1);
    chk("lit_edge_we", {7'd0, bus.cell_we}, 8'd1);
    chk("lit_edge_err", bus.err_cnt, 8'd4);

    // corner cell with idle gaps between bytes
    step(1'b1, 8'hA5); idle(2);
    step(1'b1, 8'd13); idle(3);
    step(1'b1, 8'd7);  idle(1);
    step(1'b1, 8'd0);
`ifdef PARSER_CHECKSUM_EN
    idle(2);
    step(1'b1, 8'd13 ^ 8'd7);
`endif
    chk("lit_corner_x", bus.x, 8'd13);
    chk("lit_corner_y", bus.y, 8'd7);

    // reset mid-packet
    step(1'b1, 8'hA5); step(1'b1, 8'h03); step(1'b1, 8'h02);
    do_reset();
    chk("lit_mrst_x", bus.x, 8'd0);
    chk("lit_mrst_err", bus.err_cnt, 8'd0);
    step(1'b1, 8'h01); step(1'b1, 8'h00);
    idle(3);

    // saturation
    for (int i = 0; i < 300; i++) send_bad();
    chk("lit_sat", bus.err_cnt, 8'd255);
    send_bad();
    chk("lit_sat_hold", bus.err_cnt, 8'd255);
    idle(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // rest of a cell packet after its header has already been sent
  task automatic send_cell_tail(input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] cv);
    step(1'b1, cx);
    step(1'b1, cy);
    step(1'b1, cv);
`ifdef PARSER_CHECKSUM_EN
    step(1'b1, cx ^ cy ^ cv);
`endif
  endtask
endmodule
